// File: rtl/ddr3_init_sequencer.sv
// ddr3_init_sequencer
//   DDR3 power-up and mode-register sequencer. From reset it holds RESET#
//   low, waits for CKE, waits tXPR, programs MR2/MR3/MR1/MR0, issues ZQCL,
//   then raises init_done. In IDLE it accepts single runtime MRS writes
//   (mrs_req/mrs_rdy, completion pulse on mrs_ack) and full re-init requests.
//
// Ports
//   clock, reset          : clock, synchronous active-low reset
//   mr0..mr3              : init-time mode register words {ba,a}
//   reinit                : full re-initialisation request (IDLE only)
//   mrs_req, mrs_data     : runtime MRS request and word {ba,a}
//   mrs_rdy               : combinational, IDLE && !reinit
//   mrs_ack               : one-cycle pulse after runtime MRS + tMOD
//   ddr_rst_n, cke, cs_n, ras_n, cas_n, we_n, ba, a, odt : DRAM pins
//   init_done             : high while in IDLE
module ddr3_init_sequencer #(
  parameter int unsigned BA_W          = 3,
  parameter int unsigned ROW_W         = 16,
  parameter int unsigned CNT_W         = 18,
  parameter int unsigned T_RESET       = 80000,
  parameter int unsigned T_CKE_WAIT    = 200000,
  parameter int unsigned T_XPR         = 72,
  parameter int unsigned T_MRD         = 4,
  parameter int unsigned T_MOD         = 12,
  parameter int unsigned T_ZQINIT      = 512,
  parameter bit          FORCE_DLL_RST = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BA_W+ROW_W-1:0] mr0,
  input  logic [BA_W+ROW_W-1:0] mr1,
  input  logic [BA_W+ROW_W-1:0] mr2,
  input  logic [BA_W+ROW_W-1:0] mr3,
  input  logic                  reinit,
  input  logic                  mrs_req,
  input  logic [BA_W+ROW_W-1:0] mrs_data,
  output logic                  mrs_rdy,
  output logic                  mrs_ack,
  output logic                  ddr_rst_n,
  output logic                  cke,
  output logic                  cs_n,
  output logic                  ras_n,
  output logic                  cas_n,
  output logic                  we_n,
  output logic [BA_W-1:0]       ba,
  output logic [ROW_W-1:0]      a,
  output logic                  odt,
  output logic                  init_done
);

  localparam int unsigned MW = BA_W + ROW_W;
  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  // Timing values that cannot be represented stop elaboration.
  if (T_RESET > CNT_MAX || T_CKE_WAIT > CNT_MAX || T_XPR > CNT_MAX ||
      T_MRD > CNT_MAX || T_MOD > CNT_MAX || T_ZQINIT > CNT_MAX ||
      T_RESET < 1 || T_CKE_WAIT < 1 || T_XPR < 1 ||
      T_MRD < 2 || T_MOD < 2 || T_ZQINIT < 2 || ROW_W < 11) begin : g_bad_cfg
    $error("ddr3_init_sequencer: illegal timing/width configuration");
  end

  localparam logic [CNT_W-1:0] C_RESET = CNT_W'(T_RESET);
  localparam logic [CNT_W-1:0] C_CKE   = CNT_W'(T_CKE_WAIT);
  localparam logic [CNT_W-1:0] C_XPR   = CNT_W'(T_XPR);
  localparam logic [CNT_W-1:0] C_MRD   = CNT_W'(T_MRD - 1);
  localparam logic [CNT_W-1:0] C_MOD   = CNT_W'(T_MOD - 1);
  localparam logic [CNT_W-1:0] C_ZQ    = CNT_W'(T_ZQINIT - 1);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_DES  = 4'b1111;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ZQCL = 4'b0110;
  localparam logic [ROW_W-1:0] ZQ_A = ROW_W'(1 << 10);

  typedef enum logic [3:0] {
    RESET_HOLD, CKE_WAIT, XPR, MRS2, MRS3, MRS1, MRS0,
    W_MRD, W_MOD, ZQCL, W_ZQ, IDLE, RMRS, R_MOD
  } state_t;

  state_t           state;
  state_t           mrd_next;  // which MRS follows the shared W_MRD wait
  logic [CNT_W-1:0] cnt;
  logic [MW-1:0]    mr0_init;

  // DLL reset is forced only on the init-time MR0 write.
  assign mr0_init = mr0 | (FORCE_DLL_RST ? MW'(1 << 8) : '0);
  assign mrs_rdy  = (state == IDLE) && !reinit;

  // Pins are assigned together with the transition into a state, so the
  // registered pin values always belong to the state currently held.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= RESET_HOLD;
      mrd_next  <= MRS3;
      cnt       <= '0;
      ddr_rst_n <= 1'b0;
      cke       <= 1'b0;
      {cs_n, ras_n, cas_n, we_n} <= CMD_DES;
      ba        <= '0;
      a         <= '0;
      odt       <= 1'b0;
      init_done <= 1'b0;
      mrs_ack   <= 1'b0;
    end else begin
      ddr_rst_n <= 1'b1;
      cke       <= 1'b1;
      {cs_n, ras_n, cas_n, we_n} <= CMD_NOP;
      ba        <= '0;
      a         <= '0;
      odt       <= 1'b0;
      init_done <= 1'b0;
      mrs_ack   <= 1'b0;
      unique case (state)
        RESET_HOLD: begin
          cke                        <= 1'b0;
          {cs_n, ras_n, cas_n, we_n} <= CMD_DES;
          if (cnt == C_ONE) begin
            state <= CKE_WAIT;
            cnt   <= C_CKE;
          end else begin
            // cnt==0 only right after reset: this edge is the first hold cycle
            cnt       <= (cnt == '0) ? C_RESET : cnt - 1'b1;
            ddr_rst_n <= 1'b0;
          end
        end
        CKE_WAIT: begin
          if (cnt == C_ONE) begin
            state <= XPR;
            cnt   <= C_XPR;
          end else begin
            cnt                        <= cnt - 1'b1;
            cke                        <= 1'b0;
            {cs_n, ras_n, cas_n, we_n} <= CMD_DES;
          end
        end
        XPR: begin
          if (cnt == C_ONE) begin
            state                      <= MRS2;
            {cs_n, ras_n, cas_n, we_n} <= CMD_MRS;
            {ba, a}                    <= mr2;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MRS2: begin state <= W_MRD; cnt <= C_MRD; mrd_next <= MRS3; end
        MRS3: begin state <= W_MRD; cnt <= C_MRD; mrd_next <= MRS1; end
        MRS1: begin state <= W_MRD; cnt <= C_MRD; mrd_next <= MRS0; end
        W_MRD: begin
          if (cnt == C_ONE) begin
            state                      <= mrd_next;
            {cs_n, ras_n, cas_n, we_n} <= CMD_MRS;
            case (mrd_next)
              MRS3:    {ba, a} <= mr3;
              MRS1:    {ba, a} <= mr1;
              default: {ba, a} <= mr0_init;
            endcase
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MRS0: begin state <= W_MOD; cnt <= C_MOD; end
        W_MOD: begin
          if (cnt == C_ONE) begin
            state                      <= ZQCL;
            {cs_n, ras_n, cas_n, we_n} <= CMD_ZQCL;
            a                          <= ZQ_A;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ZQCL: begin state <= W_ZQ; cnt <= C_ZQ; end
        W_ZQ: begin
          if (cnt == C_ONE) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        IDLE: begin
          if (reinit) begin
            state                      <= RESET_HOLD;
            cnt                        <= C_RESET;
            ddr_rst_n                  <= 1'b0;
            cke                        <= 1'b0;
            {cs_n, ras_n, cas_n, we_n} <= CMD_DES;
          end else if (mrs_req) begin
            // the registered pins are the latch for the runtime word
            state                      <= RMRS;
            {cs_n, ras_n, cas_n, we_n} <= CMD_MRS;
            {ba, a}                    <= mrs_data;
          end else begin
            init_done <= 1'b1;
          end
        end
        RMRS: begin state <= R_MOD; cnt <= C_MOD; end
        R_MOD: begin
          if (cnt == C_ONE) begin
            state     <= IDLE;
            init_done <= 1'b1;
            mrs_ack   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= RESET_HOLD;
          cnt   <= C_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_init_sequencer.sv
// Testbench for ddr3_init_sequencer: a timeline model (offsets from the start
// of init / runtime MRS) predicts every pin each cycle; literal checks pin
// the model to hand-computed cycle numbers.
module tb_ddr3_init_sequencer;

  localparam int BA_W = 3, ROW_W = 16, MW = BA_W + ROW_W;
  localparam int TR = 4, TC = 6, TX = 3, TMRD = 2, TMOD = 3, TZQ = 5;
  localparam int M2 = TR + TC + TX, M3 = M2 + TMRD, M1 = M3 + TMRD, M0 = M1 + TMRD;
  localparam int ZQ = M0 + TMOD, DONE = ZQ + TZQ;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [MW-1:0] mr0, mr1, mr2, mr3, mrs_data;
  logic reinit = 1'b0, mrs_req = 1'b0;
  logic mrs_rdy, mrs_ack, ddr_rst_n, cke, cs_n, ras_n, cas_n, we_n, odt, init_done;
  logic [BA_W-1:0] ba;
  logic [ROW_W-1:0] a;

  ddr3_init_sequencer #(
    .BA_W(BA_W), .ROW_W(ROW_W), .CNT_W(18), .T_RESET(TR), .T_CKE_WAIT(TC),
    .T_XPR(TX), .T_MRD(TMRD), .T_MOD(TMOD), .T_ZQINIT(TZQ), .FORCE_DLL_RST(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .mr0(mr0), .mr1(mr1), .mr2(mr2), .mr3(mr3),
    .reinit(reinit), .mrs_req(mrs_req), .mrs_data(mrs_data), .mrs_rdy(mrs_rdy),
    .mrs_ack(mrs_ack), .ddr_rst_n(ddr_rst_n), .cke(cke), .cs_n(cs_n),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .ba(ba), .a(a), .odt(odt),
    .init_done(init_done)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_pass = 0, cyc = 0, mrs_cnt = 0;
  int init_start = 0, rm_start = -1;
  logic [MW-1:0] rm_word;
  logic started = 1'b0;
  logic exp_rst, exp_cke, exp_done = 1'b0, exp_ack;
  logic [3:0] exp_cmd;
  logic [BA_W-1:0] exp_ba;
  logic [ROW_W-1:0] exp_a;
  logic [3:0] cmd;
  assign cmd = {cs_n, ras_n, cas_n, we_n};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
  endtask

  // Expected pins for cycle n from the timeline offsets.
  task automatic model_eval(input int n);
    int d, e;
    exp_rst = 1'b1; exp_cke = 1'b1; exp_cmd = 4'b0111; exp_ba = '0; exp_a = '0;
    exp_done = 1'b0; exp_ack = 1'b0;
    if (rm_start >= 0) begin
      e = n - rm_start;
      if (e == 0) begin exp_cmd = 4'b0000; {exp_ba, exp_a} = rm_word; end
      else if (e >= TMOD) begin exp_done = 1'b1; exp_ack = (e == TMOD); end
    end else begin
      d = n - init_start;
      if (d < TR) begin exp_rst = 1'b0; exp_cke = 1'b0; exp_cmd = 4'b1111; end
      else if (d < TR + TC) begin exp_cke = 1'b0; exp_cmd = 4'b1111; end
      else if (d == M2) begin exp_cmd = 4'b0000; {exp_ba, exp_a} = mr2; end
      else if (d == M3) begin exp_cmd = 4'b0000; {exp_ba, exp_a} = mr3; end
      else if (d == M1) begin exp_cmd = 4'b0000; {exp_ba, exp_a} = mr1; end
      else if (d == M0) begin exp_cmd = 4'b0000; {exp_ba, exp_a} = mr0 | 19'h00100; end
      else if (d == ZQ) begin exp_cmd = 4'b0110; exp_a = 16'h0400; end
      else if (d >= DONE) exp_done = 1'b1;
    end
  endtask

  // One clock: check mrs_rdy for the inputs just set, advance the model at
  // the edge, then compare every pin.
  task automatic step();
    #1;
    if (started) chk("mrs_rdy", 32'(mrs_rdy), 32'(exp_done && !reinit));
    @(posedge clock);
    cyc++;
    if (!reset) begin
      init_start = cyc + 1; rm_start = -1;
    end else if (exp_done) begin
      if (reinit) begin init_start = cyc; rm_start = -1; end
      else if (mrs_req) begin rm_start = cyc; rm_word = mrs_data; end
    end
    model_eval(cyc);
    #1;
    started = 1'b1;
    if (cmd == 4'b0000) mrs_cnt++;
    chk("ddr_rst_n", 32'(ddr_rst_n), 32'(exp_rst));
    chk("cke", 32'(cke), 32'(exp_cke));
    chk("cmd", 32'(cmd), 32'(exp_cmd));
    chk("ba", 32'(ba), 32'(exp_ba));
    chk("a", 32'(a), 32'(exp_a));
    chk("init_done", 32'(init_done), 32'(exp_done));
    chk("mrs_ack", 32'(mrs_ack), 32'(exp_ack));
    chk("odt", 32'(odt), 32'd0);
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  // Three reset edges; the next edge is cycle 0.
  task automatic do_reset();
    reset = 1'b0;
    cyc = -4;
    repeat (3) step();
    reset = 1'b1;
  endtask

  initial begin
    mr0 = 19'h00520; mr1 = {3'd1, 16'h0006}; mr2 = {3'd2, 16'h0018};
    mr3 = {3'd3, 16'h0000}; mrs_data = '0;

    // Init timeline, runtime MRS, reinit colliding with mrs_req
    do_reset();
    run_to(0);  chk("lit_c0_rst_n", 32'(ddr_rst_n), 32'd0);
    run_to(3);  chk("lit_c3_rst_n", 32'(ddr_rst_n), 32'd0);
    run_to(4);  chk("lit_c4_rst_n", 32'(ddr_rst_n), 32'd1);
    run_to(9);  chk("lit_c9_cke", 32'(cke), 32'd0);
    run_to(10); chk("lit_c10_cke", 32'(cke), 32'd1);
    run_to(13); chk("lit_c13_cmd", 32'(cmd), 32'h0); chk("lit_c13_ba", 32'(ba), 32'd2);
    run_to(15); chk("lit_c15_ba", 32'(ba), 32'd3);
    run_to(17); chk("lit_c17_ba", 32'(ba), 32'd1);
    run_to(19); chk("lit_c19_ba", 32'(ba), 32'd0); chk("lit_c19_a", 32'(a), 32'h0520);
    run_to(22); chk("lit_c22_cmd", 32'(cmd), 32'h6); chk("lit_c22_a", 32'(a), 32'h0400);
    run_to(26); chk("lit_c26_done", 32'(init_done), 32'd0);
    run_to(27); chk("lit_c27_done", 32'(init_done), 32'd1);
    run_to(30);
    mrs_req = 1'b1; mrs_data = 19'h1_0044;
    step();
    mrs_req = 1'b0;
    chk("lit_c31_cmd", 32'(cmd), 32'h0); chk("lit_c31_ba", 32'(ba), 32'd1);
    chk("lit_c31_a", 32'(a), 32'h0044);
    run_to(33); chk("lit_c33_ack", 32'(mrs_ack), 32'd0);
    run_to(34); chk("lit_c34_ack", 32'(mrs_ack), 32'd1);
    run_to(35); chk("lit_c35_ack", 32'(mrs_ack), 32'd0);
    run_to(40);
    reinit = 1'b1; mrs_req = 1'b1; mrs_data = 19'h2_0011;
    #1 chk("lit_c40_rdy", 32'(mrs_rdy), 32'd0);
    step();
    reinit = 1'b0; mrs_req = 1'b0;
    chk("lit_c41_done", 32'(init_done), 32'd0); chk("lit_c41_rst_n", 32'(ddr_rst_n), 32'd0);
    chk("lit_c41_cke", 32'(cke), 32'd0); chk("lit_c41_cmd", 32'(cmd), 32'hF);
    run_to(67); chk("lit_c67_done", 32'(init_done), 32'd0);
    run_to(68); chk("lit_c68_done", 32'(init_done), 32'd1);

    // MR0 without a[8]: the DLL reset bit must still appear
    mr0 = 19'h00420;
    do_reset();
    run_to(19); chk("lit_p2_c19_a", 32'(a), 32'h0520); chk("lit_p2_c19_ba", 32'(ba), 32'd0);
    run_to(28);

    // Reset in the middle of W_MRD
    mr0 = 19'h00520;
    do_reset();
    run_to(16);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("lit_p3_rst_n", 32'(ddr_rst_n), 32'd0); chk("lit_p3_cke", 32'(cke), 32'd0);
    chk("lit_p3_cmd", 32'(cmd), 32'hF); chk("lit_p3_ba", 32'(ba), 32'd0);
    chk("lit_p3_a", 32'(a), 32'd0); chk("lit_p3_done", 32'(init_done), 32'd0);
    mrs_cnt = 0;
    run_to(30); chk("lit_p3_no_mrs", 32'(mrs_cnt), 32'd0);
    run_to(31); chk("lit_p3_mrs2", 32'(cmd), 32'h0); chk("lit_p3_mrs2_ba", 32'(ba), 32'd2);
    run_to(50);

    // mrs_req held high through init
    mrs_req = 1'b1; mrs_data = {3'd3, 16'h0123};
    do_reset();
    mrs_cnt = 0;
    run_to(27); chk("lit_p4_mrs_cnt", 32'(mrs_cnt), 32'd4);
    step();
    mrs_req = 1'b0;
    chk("lit_p4_c28_cmd", 32'(cmd), 32'h0); chk("lit_p4_c28_ba", 32'(ba), 32'd3);
    chk("lit_p4_c28_a", 32'(a), 32'h0123);
    run_to(30); chk("lit_p4_c30_ack", 32'(mrs_ack), 32'd0);
    run_to(31); chk("lit_p4_c31_ack", 32'(mrs_ack), 32'd1);
    run_to(34);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ddr3_init_sequencer.md
Name: ddr3_init_sequencer

Overview:
Parametrised DDR3 power-up and mode-register sequencer that drives the DRAM command pins from reset until the device is ready. It runs RESET# hold, CKE wait, tXPR, MR2/MR3/MR1/MR0 programming, then ZQCL, and finally asserts init_done. After init it accepts runtime single-MRS requests through a ready/ack handshake, and it supports a full re-initialisation request. It sits between the controller core (which muxes in its own commands once init_done=1) and the PHY pin registers.

Parameters:
BA_W, 3, bank address width
ROW_W, 16, address bus width; each MR word is BA_W+ROW_W bits, with {ba, a} and ba in the MSBs
CNT_W, 18, delay counter width; must hold the largest T_* value
T_RESET, 80000, cycles ddr_rst_n held low (200 us at 400 MHz)
T_CKE_WAIT, 200000, cycles from ddr_rst_n high to cke high (500 us)
T_XPR, 72, cycles from cke high to first MRS
T_MRD, 4, MRS-to-MRS command spacing in cycles; minimum 2
T_MOD, 12, MRS-to-non-MRS spacing in cycles; minimum 2
T_ZQINIT, 512, cycles from ZQCL to init_done; minimum 2
FORCE_DLL_RST, 1, when 1, a[8] is forced to 1 on the init-time MR0 write

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-low reset
mr0  in  BA_W+ROW_W  MR0 value {ba,a}
mr1  in  BA_W+ROW_W  MR1 value
mr2  in  BA_W+ROW_W  MR2 value
mr3  in  BA_W+ROW_W  MR3 value
reinit  in  1  request for a full re-initialisation; honoured only in IDLE
mrs_req  in  1  runtime MRS request
mrs_data  in  BA_W+ROW_W  runtime MRS word {ba,a}
mrs_rdy  out  1  combinational: state==IDLE && !reinit
mrs_ack  out  1  one-cycle pulse when the runtime MRS has completed tMOD
ddr_rst_n  out  1  DRAM RESET#
cke  out  1  clock enable
cs_n, ras_n, cas_n, we_n  out  1 each  command pins
ba  out  BA_W  bank address
a  out  ROW_W  address
odt  out  1  held at 0 throughout this block
init_done  out  1  high while in IDLE

Behaviour:
- Clocking and reset: all state and outputs are registered on the rising edge of clock. Outputs are registered alongside the state, so pin values match the state in the same cycle it is entered.
- Reset values (reset=0 at any edge, in any state, including mid-sequence): state=RESET_HOLD, counter=0, ddr_rst_n=0, cke=0, cs_n/ras_n/cas_n/we_n=1, ba=0, a=0, odt=0, init_done=0, mrs_ack=0.
- Command encodings (cs_n,ras_n,cas_n,we_n):
  - NOP = 0111.
  - MRS = 0000.
  - ZQCL = 0110, with a[10]=1, all other a bits 0, ba=0.
  - Outside command cycles the pins carry NOP with ba=0 and a=0, except in RESET_HOLD and CKE_WAIT, where they carry DES (cs_n=1).
- Wait timing: each wait state is a down-counter loaded on entry. The state is exited when the count reaches 1. "Lasts N" means exactly N cycles.
- State sequence:
  - RESET_HOLD: lasts T_RESET. ddr_rst_n=0, cke=0.
  - CKE_WAIT: lasts T_CKE_WAIT. ddr_rst_n=1, cke=0.
  - XPR: lasts T_XPR. cke=1, NOP.
  - MRS2 (1 cycle), then W_MRD (T_MRD-1 cycles).
  - MRS3 (1 cycle), then W_MRD (T_MRD-1 cycles).
  - MRS1 (1 cycle), then W_MRD (T_MRD-1 cycles).
  - MRS0 (1 cycle), then W_MOD (T_MOD-1 cycles).
  - ZQCL (1 cycle), then W_ZQ (T_ZQINIT-1 cycles).
  - IDLE.
- Mode-register sourcing:
  - MRSn drives {ba,a} = mrn, sampled in the command cycle.
  - MR0 has a[8] ORed with FORCE_DLL_RST.
  - cke stays 1 from XPR onward.
- IDLE:
  - init_done=1, NOP.
  - If reinit=1, go to RESET_HOLD next cycle: init_done=0, ddr_rst_n=0, cke=0.
  - Else if mrs_req=1 (accept = mrs_req && mrs_rdy), latch mrs_data and go to RMRS.
  - Simultaneous reinit and mrs_req: reinit wins and the request is not accepted.
- Runtime MRS path:
  - RMRS: 1 cycle; MRS with {ba,a} = latched word, no DLL force; init_done=0.
  - R_MOD: T_MOD-1 cycles, NOP.
  - Return to IDLE with mrs_ack=1 for exactly that first IDLE cycle.
  - mrs_req is ignored outside IDLE.
  - Changes to mr0..mr3 after their MRS cycle have no effect until the next reinit.
- Counter width: CNT_W bits; a T_* value that does not fit in CNT_W is a configuration error.

Test Plan:
Setup for all tests: T_RESET=4, T_CKE_WAIT=6, T_XPR=3, T_MRD=2, T_MOD=3, T_ZQINIT=5. Cycle 0 is the first edge with reset=1.
1. Init timeline: ddr_rst_n=0 on cycles 0-3 and 1 from cycle 4; cke=1 from cycle 10. MRS on cycles 13/15/17/19 with ba=2/3/1/0. ZQCL on cycle 22 with a=0x0400. init_done=1 from cycle 27.
2. MR content: mr0=0x00520, FORCE_DLL_RST=1 -> cycle 19 shows ba=0, a=0x0520|0x0100=0x0520 (a[8] already set). Repeat with mr0=0x00420 -> a=0x0520.
3. Runtime MRS: mrs_req=1 with mrs_data=0x1_0044 accepted at cycle 30 -> cycle 31 shows MRS with ba=1, a=0x0044. mrs_rdy=0 on cycles 31-33; mrs_ack=1 on cycle 34 only.
4. reinit and mrs_req both high in IDLE at cycle 40 -> mrs_rdy=0 and no MRS issued. Cycle 41: init_done=0, ddr_rst_n=0, cke=0, followed by the full 27-cycle sequence again.
5. reset=0 asserted at cycle 16 (mid-W_MRD) -> cycle 17 shows all reset values. After release, the sequence restarts from RESET_HOLD with no stray MRS.
6. mrs_req held high throughout init -> no MRS other than the four init writes. Accepted on the first IDLE cycle (27) -> MRS at cycle 28, mrs_ack at cycle 31.
